sram_bank_ctrl: RTL and testbench

//  Parametrised controller for a GF180 256x8 SRAM macro array (BANKS deep x DATA_W/8 lanes wide).

---
 rtl/sram_ctrl_pkg.sv | 21 ++
 rtl/sram_ctrl_arb.sv | 51 +++++
 rtl/sram_bank_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sram_bank_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared macro geometry and clear-FSM state encoding for the
//               SRAM bank controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

    localparam int MACRO_AW = 8;
    localparam int MACRO_DW = 8;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/sram_ctrl_arb.sv
// ============================================================================
// Module      : sram_ctrl_arb
// Description : Core-priority two-port arbiter with a saturating host
//               starvation counter that forces one host slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_ctrl_arb #(
    parameter int STARVE_MAX = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic core_req_i,
    input  logic host_req_i,
    input  logic ready_i,
    output logic core_sel_o,
    output logic host_forced_o,
    output logic host_gnt_o
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_host_sel;

    always_comb begin
        host_forced_o = (cnt_q == CNT_W'(STARVE_MAX)) && host_req_i;
        w_host_sel    = host_forced_o || (!core_req_i && host_req_i);
        core_sel_o    = core_req_i && !host_forced_o;
        host_gnt_o    = w_host_sel && ready_i;
        cnt_d         = cnt_q;
        if (host_gnt_o) begin
            cnt_d = '0;
        end else if (host_req_i && (cnt_q != CNT_W'(STARVE_MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_bank_ctrl.sv
// ============================================================================
// Module      : sram_bank_ctrl
// Description : Two-port (core/host) controller for an array of 256x8 SRAM
//               macros. Optional power-up clear: SRAM_CTRL_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bank_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 7
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  core_en,
    input  logic                                  core_we,
    input  logic [DATA_W/8-1:0]                   core_be,
    input  logic [ADDR_W-1:0]                     core_addr,
    input  logic [DATA_W-1:0]                     core_wdata,
    output logic                                  core_stall,
    output logic [DATA_W-1:0]                     core_rdata,
    input  logic                                  host_req,
    input  logic                                  host_we,
    input  logic [ADDR_W-1:0]                     host_addr,
    input  logic [DATA_W-1:0]                     host_wdata,
    output logic                                  host_gnt,
    output logic                                  host_rvalid,
    output logic [DATA_W-1:0]                     host_rdata,
    output logic                                  ready,
    output logic [2**(ADDR_W-MACRO_AW)-1:0]       sram_cen_n,
    output logic [2**(ADDR_W-MACRO_AW)-1:0]       sram_gwen_n,
    output logic [DATA_W-1:0]                     sram_wen_n,
    output logic [MACRO_AW-1:0]                   sram_a,
    output logic [DATA_W-1:0]                     sram_d,
    input  logic [(2**(ADDR_W-MACRO_AW))*DATA_W-1:0] sram_q
);

    localparam int BANKS  = 2**(ADDR_W - MACRO_AW);
    localparam int LANES  = DATA_W / MACRO_DW;
    localparam int BANK_W = (ADDR_W > MACRO_AW) ? (ADDR_W - MACRO_AW) : 1;

    logic              w_ready;
    logic              w_go;
    logic              w_core_req;
    logic              w_core_sel;
    logic              w_host_forced;
    logic              w_host_gnt;
    logic              w_act;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_wmask;
    logic [BANK_W-1:0] w_bank;
    logic [DATA_W-1:0] w_q_sel;

    logic [BANK_W-1:0] rd_bank_q;
    logic              rd_host_q;
    logic [DATA_W-1:0] host_rdata_q;

`ifdef SRAM_CTRL_CLEAR_EN
    clr_state_e          state_q;
    clr_state_e          state_d;
    logic [MACRO_AW-1:0] clr_addr_q;
    logic [MACRO_AW-1:0] clr_addr_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == S_CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign w_ready = (state_q == S_RUN);
`else
    assign w_ready = 1'b1;
`endif

    assign ready = w_ready;
    assign w_go  = reset_n && w_ready;

    // A core write with no byte lanes enabled is a no-op and does not compete.
    assign w_core_req = core_en && (!core_we || (|core_be));

    sram_ctrl_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk           (clk),
        .reset_n       (reset_n),
        .core_req_i    (w_core_req),
        .host_req_i    (host_req),
        .ready_i       (w_go),
        .core_sel_o    (w_core_sel),
        .host_forced_o (w_host_forced),
        .host_gnt_o    (w_host_gnt)
    );

    assign core_stall = reset_n && w_core_req && (w_host_forced || !w_ready);
    assign host_gnt   = w_host_gnt;

    always_comb begin
        w_wmask = '0;
        for (int l = 0; l < LANES; l++) begin
            w_wmask[l*MACRO_DW +: MACRO_DW] = {MACRO_DW{core_be[l]}};
        end
        w_addr  = core_addr;
        w_we    = core_we;
        w_wdata = core_wdata;
        w_act   = w_core_sel && w_go;
        if (w_host_gnt) begin
            w_addr  = host_addr;
            w_we    = host_we;
            w_wdata = host_wdata;
            w_wmask = '1;
            w_act   = 1'b1;
        end
    end

    generate
        if (ADDR_W > MACRO_AW) begin : g_bank_dec
            assign w_bank = w_addr[ADDR_W-1:MACRO_AW];
        end else begin : g_bank_one
            assign w_bank = '0;
        end
    endgenerate

    always_comb begin
        sram_cen_n  = '1;
        sram_gwen_n = '1;
        sram_wen_n  = '1;
        sram_a      = w_addr[MACRO_AW-1:0];
        sram_d      = w_wdata;
        if (w_act) begin
            sram_cen_n[w_bank] = 1'b0;
            if (w_we) begin
                sram_gwen_n[w_bank] = 1'b0;
                sram_wen_n          = ~w_wmask;
            end
        end
`ifdef SRAM_CTRL_CLEAR_EN
        // Every bank zeroes the same macro row in parallel.
        if (reset_n && (state_q == S_CLEAR)) begin
            sram_cen_n  = '0;
            sram_gwen_n = '0;
            sram_wen_n  = '0;
            sram_a      = clr_addr_q;
            sram_d      = '0;
        end
`endif
    end

    assign w_q_sel = sram_q[int'(rd_bank_q)*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_bank_q    <= '0;
            rd_host_q    <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            rd_host_q <= w_host_gnt && !host_we;
            if (w_act && !w_we) begin
                rd_bank_q <= w_bank;
            end
            if (rd_host_q) begin
                host_rdata_q <= w_q_sel;
            end
        end
    end

    // Macro Q holds until the bank's next access, so the core path is a plain mux.
    assign core_rdata  = w_q_sel;
    assign host_rvalid = rd_host_q;
    assign host_rdata  = rd_host_q ? w_q_sel : host_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_bank_ctrl.sv
// ============================================================================
// Module      : tb_sram_bank_ctrl
// Description : Self-checking bench for sram_bank_ctrl with behavioural
//               256x8 macro models and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_bank_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int BANKS  = 4;

    logic                    clk;
    logic                    reset_n;
    logic                    core_en;
    logic                    core_we;
    logic [1:0]              core_be;
    logic [ADDR_W-1:0]       core_addr;
    logic [DATA_W-1:0]       core_wdata;
    logic                    core_stall;
    logic [DATA_W-1:0]       core_rdata;
    logic                    host_req;
    logic                    host_we;
    logic [ADDR_W-1:0]       host_addr;
    logic [DATA_W-1:0]       host_wdata;
    logic                    host_gnt;
    logic                    host_rvalid;
    logic [DATA_W-1:0]       host_rdata;
    logic                    ready;
    logic [BANKS-1:0]        sram_cen_n;
    logic [BANKS-1:0]        sram_gwen_n;
    logic [DATA_W-1:0]       sram_wen_n;
    logic [7:0]              sram_a;
    logic [DATA_W-1:0]       sram_d;
    logic [BANKS*DATA_W-1:0] sram_q;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem     [BANKS][256];
    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    logic [DATA_W-1:0] exp_q   [$];

    sram_bank_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (7)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .core_en     (core_en),
        .core_we     (core_we),
        .core_be     (core_be),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_stall  (core_stall),
        .core_rdata  (core_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ready       (ready),
        .sram_cen_n  (sram_cen_n),
        .sram_gwen_n (sram_gwen_n),
        .sram_wen_n  (sram_wen_n),
        .sram_a      (sram_a),
        .sram_d      (sram_d),
        .sram_q      (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macros: write completes at the edge, Q updates on read.
    always @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (!sram_cen_n[b]) begin
                if (!sram_gwen_n[b]) begin
                    mem[b][sram_a] <= (mem[b][sram_a] & sram_wen_n) | (sram_d & ~sram_wen_n);
                end else begin
                    sram_q[b*DATA_W +: DATA_W] <= mem[b][sram_a];
                end
            end
        end
    end

    task automatic idle();
        core_en = 0; core_we = 0; core_be = 0; core_addr = '0; core_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic do_reset();
        int n;
        reset_n = 0;
        idle();
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
`ifdef SRAM_CTRL_CLEAR_EN
        n = 0;
        @(negedge clk);
        while (!ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL clear_len: got %0d cycles, expected 256", n);
        end
        for (int a = 0; a < 2**ADDR_W; a++) ref_mem[a] = '0;
`endif
    endtask

    task automatic core_op(input logic we, input logic [1:0] be, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, output logic [BANKS-1:0] cen);
        int n;
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] e;
        @(posedge clk); #1;
        core_en = 1; core_we = we; core_be = be; core_addr = addr; core_wdata = wd;
        n = 0;
        @(negedge clk);
        while (core_stall && n < 50) begin n++; @(negedge clk); end
        cen = sram_cen_n;
        checks++;
        if (core_stall) begin
            failures++;
            $display("FAIL core_accept: stall still %b after %0d cycles, expected 0", core_stall, n);
        end
        if (!we) begin
            exp_q.push_back(ref_mem[addr]);
        end else begin
            m = {{8{be[1]}}, {8{be[0]}}};
            ref_mem[addr] = (ref_mem[addr] & ~m) | (wd & m);
        end
        @(posedge clk); #1;
        core_en = 0;
        if (!we) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (core_rdata !== e) begin
                failures++;
                $display("FAIL core_rdata @%h: got %h expected %h", addr, core_rdata, e);
            end
        end
    endtask

    task automatic host_op(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, output logic [BANKS-1:0] cen);
        int n;
        logic [DATA_W-1:0] e;
        @(posedge clk); #1;
        host_req = 1; host_we = we; host_addr = addr; host_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!host_gnt && n < 50) begin n++; @(negedge clk); end
        cen = sram_cen_n;
        checks++;
        if (!host_gnt) begin
            failures++;
            $display("FAIL host_grant: gnt %b after %0d cycles, expected 1", host_gnt, n);
        end
        if (we) ref_mem[addr] = wd;
        else    exp_q.push_back(ref_mem[addr]);
        @(posedge clk); #1;
        host_req = 0;
        if (!we) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (host_rvalid !== 1'b1 || host_rdata !== e) begin
                failures++;
                $display("FAIL host_read @%h: rvalid %b data %h, expected rvalid 1 data %h",
                         addr, host_rvalid, host_rdata, e);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle();
        core_en = 1; host_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b0 || host_gnt !== 1'b0 || host_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: stall %b gnt %b rvalid %b, expected 0 0 0",
                     core_stall, host_gnt, host_rvalid);
        end
        checks++;
        if (host_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 0000", host_rdata);
        end
        checks++;
        if (sram_cen_n !== 4'hF || sram_gwen_n !== 4'hF || sram_wen_n !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_macro: cen %h gwen %h wen %h, expected f f ffff",
                     sram_cen_n, sram_gwen_n, sram_wen_n);
        end
        do_reset();
`ifndef SRAM_CTRL_CLEAR_EN
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ready: got %b expected 1", ready);
        end
`endif
    endtask

    task automatic test_host_rw();
        logic [BANKS-1:0] cen;
        host_op(1, 10'h155, 16'hA5C3, cen);
        checks++;
        if (cen !== 4'b1101) begin
            failures++;
            $display("FAIL host_wr_cen: got %b expected 1101", cen);
        end
        host_op(0, 10'h155, '0, cen);
    endtask

    task automatic test_core_be();
        logic [BANKS-1:0] cen;
        core_op(1, 2'b11, 10'h0FF, 16'hFFFF, cen);
        core_op(1, 2'b01, 10'h0FF, 16'h1234, cen);
        checks++;
        if (ref_mem[10'h0FF] !== 16'hFF34) begin
            failures++;
            $display("FAIL be_model: got %h expected ff34", ref_mem[10'h0FF]);
        end
        // Zero byte-enable write: no stall and no macro enable.
        @(posedge clk); #1;
        core_en = 1; core_we = 1; core_be = 2'b00; core_addr = 10'h0FF; core_wdata = 16'h0000;
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b0 || sram_cen_n !== 4'hF) begin
            failures++;
            $display("FAIL be_zero: stall %b cen %h, expected 0 f", core_stall, sram_cen_n);
        end
        @(posedge clk); #1;
        core_en = 0;
        core_op(0, 2'b00, 10'h0FF, '0, cen);
    endtask

    task automatic test_banks();
        logic [BANKS-1:0] cen;
        logic [BANKS-1:0] want;
        for (int i = 0; i < BANKS; i++) begin
            host_op(1, ADDR_W'(i << 8), DATA_W'(16'hB000 + i * 16'h0111), cen);
        end
        for (int i = 0; i < BANKS; i++) begin
            core_op(0, 2'b00, ADDR_W'(i << 8), '0, cen);
            want = ~(BANKS'(1) << i);
            checks++;
            if (cen !== want) begin
                failures++;
                $display("FAIL bank_cen %0d: got %b expected %b", i, cen, want);
            end
        end
    endtask

    task automatic test_starve();
        logic [BANKS-1:0] cen;
        int gcyc;
        int early;
        logic stall_at;
        @(posedge clk); #1;
        core_en = 1; core_we = 0; core_be = 0; core_addr = 10'h000;
        host_req = 1; host_we = 1; host_addr = 10'h201; host_wdata = 16'hBEEF;
        gcyc = 0; early = 0; stall_at = 0;
        for (int c = 1; c <= 20 && gcyc == 0; c++) begin
            @(negedge clk);
            if (host_gnt) begin
                gcyc = c;
                stall_at = core_stall;
            end else if (core_stall) begin
                early++;
            end
        end
        checks++;
        if (gcyc != 8) begin
            failures++;
            $display("FAIL starve_cycle: got %0d expected 8", gcyc);
        end
        checks++;
        if (stall_at !== 1'b1 || early != 0) begin
            failures++;
            $display("FAIL starve_stall: at grant %b early %0d, expected 1 0", stall_at, early);
        end
        if (gcyc != 0) ref_mem[10'h201] = 16'hBEEF;
        @(posedge clk); #1;
        idle();
        host_op(0, 10'h201, '0, cen);
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        core_en = 1; core_we = 1; core_be = 2'b11; core_addr = 10'h3C7; core_wdata = 16'h5A69;
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_wr_stall: got %b expected 0", core_stall);
        end
        ref_mem[10'h3C7] = 16'h5A69;
        @(posedge clk); #1;
        core_we = 0;
        exp_q.push_back(ref_mem[10'h3C7]);
        @(posedge clk); #1;
        core_en = 0;
        @(negedge clk);
        checks++;
        if (core_rdata !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL b2b_read: got %h expected 5a69", core_rdata);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        host_req = 1; host_we = 0; host_addr = 10'h155;
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b1) begin
            failures++;
            $display("FAIL mid_grant: got %b expected 1", host_gnt);
        end
        reset_n = 0;
        #1;
        checks++;
        if (sram_cen_n !== 4'hF || host_gnt !== 1'b0) begin
            failures++;
            $display("FAIL mid_macro: cen %h gnt %b, expected f 0", sram_cen_n, host_gnt);
        end
        host_req = 0;
        @(posedge clk); #1;
        checks++;
        if (host_rvalid !== 1'b0 || host_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL mid_rvalid: rvalid %b data %h, expected 0 0000", host_rvalid, host_rdata);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (host_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_after: rvalid %b expected 0", host_rvalid);
        end
    endtask

`ifdef SRAM_CTRL_CLEAR_EN
    task automatic test_clear();
        logic [BANKS-1:0] cen;
        reset_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        core_en = 1; core_we = 0; core_addr = 10'h2AB;
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_stall: stall %b ready %b, expected 1 0", core_stall, ready);
        end
        core_en = 0;
        repeat (300) @(posedge clk);
        for (int a = 0; a < 2**ADDR_W; a++) ref_mem[a] = '0;
        core_op(0, 2'b00, 10'h2AB, '0, cen);
        host_op(0, 10'h0FF, '0, cen);
    endtask
`endif

    initial begin
        reset_n = 0;
        idle();
        test_reset();
        test_host_rw();
        test_core_be();
        test_banks();
        test_starve();
        test_back_to_back();
        test_reset_mid();
`ifdef SRAM_CTRL_CLEAR_EN
        test_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
